// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the shared memory port.
// master is the arbiter's view; slave is the view of the requesters plus the memory.
interface mem_port_arbiter_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;

    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (
        input  imem_addr, imem_rmask,
        output imem_rdata, imem_resp,
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp,
        output mem_addr, mem_rmask, mem_wmask, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        output imem_addr, imem_rmask,
        input  imem_rdata, imem_resp,
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp,
        input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between fetch and load/store.
// Request pulses are held in per-requester slots; one access is in flight at a time.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.master   bus,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
    typedef enum logic {IMEM = 1'b0, DMEM = 1'b1} req_t;

    state_t      state, state_next;
    req_t        last_grant, grant_next;

    logic        i_pend, d_pend;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  i_rmask, d_rmask, d_wmask;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  rmask_q, wmask_q;
    logic        i_req, d_req, done;

    always_comb begin
        i_req = (bus.imem_rmask != '0) && !i_pend;
        d_req = ((bus.dmem_rmask | bus.dmem_wmask) != '0) && !d_pend;
        done  = (state == WAIT) && bus.mem_resp;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant_next = last_grant;
        case (state)
            IDLE: if (i_pend || d_pend) begin
                state_next = ISSUE;
                if (i_pend && d_pend) grant_next = (last_grant == IMEM) ? DMEM : IMEM;
                else                  grant_next = d_pend ? DMEM : IMEM;
            end
            ISSUE:   state_next = WAIT;
            WAIT:    if (bus.mem_resp) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A slot stays pending while its access is in flight; it clears only on the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IMEM;
            i_pend <= 1'b0;  i_addr <= '0;  i_rmask <= '0;
            d_pend <= 1'b0;  d_addr <= '0;  d_rmask <= '0;  d_wmask <= '0;  d_wdata <= '0;
            addr_q <= '0;  wdata_q <= '0;  rmask_q <= '0;  wmask_q <= '0;
        end else begin
            last_grant <= grant_next;
            if (i_req) begin
                i_pend  <= 1'b1;
                i_addr  <= bus.imem_addr;
                i_rmask <= bus.imem_rmask;
            end else if (done && last_grant == IMEM) begin
                i_pend <= 1'b0;
            end
            if (d_req) begin
                d_pend  <= 1'b1;
                d_addr  <= bus.dmem_addr;
                d_rmask <= bus.dmem_rmask;
                d_wmask <= bus.dmem_wmask;
                d_wdata <= bus.dmem_wdata;
            end else if (done && last_grant == DMEM) begin
                d_pend <= 1'b0;
            end
            if (state == IDLE && state_next == ISSUE) begin
                if (grant_next == DMEM) begin
                    addr_q <= d_addr;  rmask_q <= d_rmask;  wmask_q <= d_wmask;  wdata_q <= d_wdata;
                end else begin
                    addr_q <= i_addr;  rmask_q <= i_rmask;  wmask_q <= '0;       wdata_q <= '0;
                end
            end
        end
    end

    always_comb begin
        bus.mem_addr   = addr_q;
        bus.mem_wdata  = wdata_q;
        bus.mem_rmask  = (state == ISSUE) ? rmask_q : '0;
        bus.mem_wmask  = (state == ISSUE) ? wmask_q : '0;
        bus.imem_resp  = done && (last_grant == IMEM);
        bus.dmem_resp  = done && (last_grant == DMEM);
        bus.imem_rdata = bus.imem_resp ? bus.mem_rdata : '0;
        bus.dmem_rdata = bus.dmem_resp ? bus.mem_rdata : '0;
    end

    if (TIMEOUT > 0) begin : g_timeout
        localparam int unsigned CW = $clog2(TIMEOUT + 1);
        localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
        logic [CW-1:0] cnt;
        logic          err;

        // The flag is sticky; the counter saturates so it never wraps while waiting on.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
                err <= 1'b0;
            end else if (state == WAIT && !bus.mem_resp) begin
                if (cnt != LIMIT)                cnt <= cnt + CW'(1);
                if (cnt == LIMIT - CW'(1))       err <= 1'b1;
            end else begin
                cnt <= '0;
            end
        end

        always_comb timeout_err = err;
    end else begin : g_no_timeout
        always_comb timeout_err = 1'b0;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the fetch requester (imem) and the load/store requester (dmem) of the pipeline.
- Captures one-cycle request pulses into pending slots and issues them to memory one at a time.
- Waits for mem_resp, then routes the response back to the owning requester.
- Sits between the fetch/memory stages and the memory model or cache.

Parameters:
TIMEOUT, 1023, max cycles to wait for mem_resp before flagging error (0 disables the check)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_addr  in  32  fetch address, sampled when imem_rmask != 0
imem_rmask  in  4  fetch read mask; nonzero for one cycle = request pulse
imem_rdata  out  32  fetch read data, valid when imem_resp
imem_resp  out  1  fetch response pulse
dmem_addr  in  32  data address, sampled when dmem_rmask|dmem_wmask != 0
dmem_rmask  in  4  load mask
dmem_wmask  in  4  store mask
dmem_wdata  in  32  store data
dmem_rdata  out  32  load data, valid when dmem_resp
dmem_resp  out  1  data response pulse
mem_addr  out  32  memory address
mem_rmask  out  4  memory read mask (one-cycle pulse)
mem_wmask  out  4  memory write mask (one-cycle pulse)
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data
mem_resp  in  1  memory response
timeout_err  out  1  sticky error flag

Behaviour:
- Reset (sync, active-high, at the clk edge):
  - state=IDLE; both pending slots cleared; last_grant=IMEM; timeout counter=0.
  - All outputs 0, including mem_* masks/addr/wdata and timeout_err.
  - Reset mid-transaction abandons the outstanding access; a later mem_resp while IDLE is ignored.
- Capture: at every edge, a nonzero request mask latches addr/masks/wdata into that requester's pending slot.
  - A requester must not pulse again before its resp; a second pulse while its slot is pending or in flight overwrites nothing and is ignored.
  - The bench asserts this never occurs.
- States:
  - IDLE: if any slot is pending (or being captured this cycle, which counts at the next edge), grant and go to ISSUE.
  - ISSUE: mem_addr/mem_rmask/mem_wmask/mem_wdata are driven from registers for exactly one cycle (pulse), then WAIT.
  - WAIT: masks are 0; mem_addr/mem_wdata hold their values. On mem_resp the granted slot clears and the state returns to IDLE.
- Grant selection:
  - One slot pending: grant it.
  - Both pending: grant the requester that is not last_grant (round-robin), so dmem wins first after reset.
  - last_grant updates on each grant.
- Latency:
  - Request pulse in cycle t -> capture at edge t -> IDLE decides in cycle t+1 -> mem mask pulse in cycle t+2.
  - Response is combinational: mem_resp in cycle r -> owner's *_resp=1 and *_rdata=mem_rdata in cycle r. The other requester's resp stays 0 and its rdata is 0.
  - A queued request issues its mem pulse in cycle r+2, giving one bubble cycle in IDLE.
- A mem_resp outside WAIT is ignored and never forwarded.
- Stores return dmem_resp with dmem_rdata=mem_rdata; the value is don't-care for the requester.
- Timeout:
  - The counter increments each WAIT cycle without mem_resp and clears on leaving WAIT.
  - On reaching TIMEOUT (TIMEOUT>0), timeout_err sets and stays set until rst.
  - The FSM keeps waiting after the flag sets.
- Counter width is clog2(TIMEOUT+1). TIMEOUT=0 means no counting, and timeout_err stays 0.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, no mem pulses, state IDLE.
- imem_rmask=4'hF, addr 0x1eceb000 at cycle 1; mem_resp with rdata 0x00000013 three cycles after the mem pulse -> mem_rmask=F in cycle 3 only, imem_resp=1 and imem_rdata=0x00000013 in the resp cycle, dmem_resp=0.
- imem and dmem (load, addr 0x1eceb100) pulse in the same cycle -> dmem issued first, imem mem pulse 2 cycles after the dmem resp, each resp routed to its owner.
- Store: dmem_wmask=4'b0011, wdata 0xdeadbeef, addr 0x1eceb202 -> one-cycle mem_wmask=0011, mem_wdata=0xdeadbeef, mem_rmask=0, then dmem_resp on mem_resp.
- Back-to-back contention over 20 requests each -> grants strictly alternate, neither requester starves, never two outstanding mem requests.
- TIMEOUT=8 and mem_resp withheld -> timeout_err rises after 8 WAIT cycles and stays high. A late mem_resp completes the access, and rst clears the flag.
